// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding select generation plus load-use and multi-cycle MUL/DIV stall control.
// FWD_SEL is registered so the select computed in ID steers the EX operand muxes next cycle.
module fwd_hazard_unit #(
    parameter int ADDR_W  = 5,
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = 2,
    parameter int SEL_W   = $clog2(NUM_FWD + 1),
    parameter int MD_LAT  = 4,
    parameter int CNT_W   = 16
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        ID_VALID,
    input  logic [NUM_SRC*ADDR_W-1:0]   SRC_ADDR_ID,
    input  logic [NUM_SRC-1:0]          SRC_USED_ID,
    input  logic [NUM_FWD*ADDR_W-1:0]   DEST_ADDR,
    input  logic [NUM_FWD-1:0]          DEST_WE,
    input  logic                        DEST_IS_LOAD,
    input  logic                        MD_START,
    output logic [NUM_SRC*SEL_W-1:0]    FWD_SEL,
    output logic                        STALL_ID,
    output logic                        FLUSH_EX,
    output logic                        MD_BUSY,
    output logic [CNT_W-1:0]            HAZARD_CNT
);

    localparam int MDC_W = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;

    typedef enum logic {IDLE, MD_WAIT} state_e;

    state_e                             state_q;
    logic [MDC_W-1:0]                   md_cnt_q;
    logic [NUM_SRC-1:0][SEL_W-1:0]      fwd_sel_q;
    logic [NUM_SRC-1:0][SEL_W-1:0]      fwd_sel_d;
    logic                               flush_q;
    logic [CNT_W-1:0]                   hz_cnt_q;

    logic [NUM_SRC-1:0][NUM_FWD-1:0]    hit;
    logic                               lu;
    logic                               lu_act;
    logic                               lu_flush;
    logic                               md_wait;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = 0; k < NUM_FWD; k++) begin
                hit[i][k] = ID_VALID & SRC_USED_ID[i] & DEST_WE[k] &
                            (DEST_ADDR[k*ADDR_W +: ADDR_W] == SRC_ADDR_ID[i*ADDR_W +: ADDR_W]) &
                            (SRC_ADDR_ID[i*ADDR_W +: ADDR_W] != '0);
            end
        end
    end

    // Scan oldest to youngest so the lowest matching stage overwrites last and wins.
    always_comb begin
        fwd_sel_d = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (hit[i][k]) fwd_sel_d[i] = SEL_W'(k + 1);
            end
        end
    end

    always_comb begin
        lu = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) lu = lu | hit[i][0];
        lu = lu & DEST_IS_LOAD;
    end

    assign md_wait  = (state_q == MD_WAIT);
    assign lu_act   = lu & ~md_wait;
    // A MUL/DIV entering EX owns the slot, so no bubble is injected for a coincident load-use.
    assign lu_flush = lu_act & ~MD_START;

    assign STALL_ID   = ~RESET & (lu_act | md_wait);
    assign MD_BUSY    = md_wait;
    assign FLUSH_EX   = flush_q;
    assign FWD_SEL    = fwd_sel_q;
    assign HAZARD_CNT = hz_cnt_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            md_cnt_q  <= '0;
            fwd_sel_q <= '0;
            flush_q   <= 1'b0;
            hz_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (MD_START) begin
                        state_q  <= MD_WAIT;
                        md_cnt_q <= MDC_W'(MD_LAT - 2);
                    end
                end
                MD_WAIT: begin
                    if (md_cnt_q == '0) state_q  <= IDLE;
                    else                md_cnt_q <= md_cnt_q - 1'b1;
                end
                default: state_q <= IDLE;
            endcase

            if (!md_wait) fwd_sel_q <= lu_flush ? '0 : fwd_sel_d;
            flush_q <= lu_flush;

            if (STALL_ID && (hz_cnt_q != '1)) hz_cnt_q <= hz_cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed-vector bench for fwd_hazard_unit with hand-computed expectations (CNT_W = 4).
module tb_fwd_hazard_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ID_VALID;
    logic [9:0]  SRC_ADDR_ID;
    logic [1:0]  SRC_USED_ID;
    logic [9:0]  DEST_ADDR;
    logic [1:0]  DEST_WE;
    logic        DEST_IS_LOAD;
    logic        MD_START;
    logic [3:0]  FWD_SEL;
    logic        STALL_ID;
    logic        FLUSH_EX;
    logic        MD_BUSY;
    logic [3:0]  HAZARD_CNT;

    int nvec = 0;
    int nerr = 0;

    fwd_hazard_unit #(.ADDR_W(5), .NUM_SRC(2), .NUM_FWD(2), .MD_LAT(4), .CNT_W(4)) dut (
        .CLK(CLK), .RESET(RESET), .ID_VALID(ID_VALID),
        .SRC_ADDR_ID(SRC_ADDR_ID), .SRC_USED_ID(SRC_USED_ID),
        .DEST_ADDR(DEST_ADDR), .DEST_WE(DEST_WE), .DEST_IS_LOAD(DEST_IS_LOAD),
        .MD_START(MD_START), .FWD_SEL(FWD_SEL), .STALL_ID(STALL_ID),
        .FLUSH_EX(FLUSH_EX), .MD_BUSY(MD_BUSY), .HAZARD_CNT(HAZARD_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        ID_VALID = 1'b0; SRC_ADDR_ID = '0; SRC_USED_ID = '0;
        DEST_ADDR = '0; DEST_WE = '0; DEST_IS_LOAD = 1'b0; MD_START = 1'b0;
    endtask

    task automatic set_src(input int i, input logic [4:0] a, input logic used);
        SRC_ADDR_ID[i*5 +: 5] = a;
        SRC_USED_ID[i] = used;
        ID_VALID = 1'b1;
    endtask

    task automatic set_dest(input int k, input logic [4:0] a, input logic we);
        DEST_ADDR[k*5 +: 5] = a;
        DEST_WE[k] = we;
    endtask

    task automatic do_reset();
        clr();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    initial begin
        // Reset: a live load-use pattern must not stall while RESET is high
        clr();
        RESET = 1'b1;
        set_dest(0, 5'd3, 1'b1); set_src(0, 5'd3, 1'b1); DEST_IS_LOAD = 1'b1;
        #1;
        chk("rst_stall", 32'(STALL_ID), 32'd0);
        tick(); tick();
        chk("rst_fwd",   32'(FWD_SEL),    32'd0);
        chk("rst_flush", 32'(FLUSH_EX),   32'd0);
        chk("rst_busy",  32'(MD_BUSY),    32'd0);
        chk("rst_cnt",   32'(HAZARD_CNT), 32'd0);
        clr();
        RESET = 1'b0;

        // ALU-to-ALU
        set_dest(0, 5'd5, 1'b1); set_src(0, 5'd5, 1'b1); set_src(1, 5'd6, 1'b1);
        #1;
        chk("alu_stall", 32'(STALL_ID), 32'd0);
        tick();
        chk("alu_fwd", 32'(FWD_SEL), 32'h1);

        // Both stages write r7: youngest wins for src1
        clr();
        set_dest(0, 5'd7, 1'b1); set_dest(1, 5'd7, 1'b1); set_src(0, 5'd0, 1'b1); set_src(1, 5'd7, 1'b1);
        tick();
        chk("prio_fwd", 32'(FWD_SEL), 32'h4);

        // x0 never forwarded from either stage
        clr();
        set_dest(0, 5'd0, 1'b1); set_dest(1, 5'd0, 1'b1); set_src(0, 5'd0, 1'b1); set_src(1, 5'd0, 1'b1);
        tick();
        chk("x0_fwd", 32'(FWD_SEL), 32'h0);

        // Stage0 not writing: stage1 forwards both sources
        clr();
        set_dest(0, 5'd7, 1'b0); set_dest(1, 5'd7, 1'b1); set_src(0, 5'd7, 1'b1); set_src(1, 5'd7, 1'b1);
        tick();
        chk("we0_fwd", 32'(FWD_SEL), 32'hA);

        // Unused sources: no forward, no load-use stall
        clr();
        set_dest(0, 5'd9, 1'b1); DEST_IS_LOAD = 1'b1; set_src(0, 5'd9, 1'b0); set_src(1, 5'd9, 1'b0);
        #1;
        chk("unused_stall", 32'(STALL_ID), 32'd0);
        tick();
        chk("unused_fwd",   32'(FWD_SEL),  32'h0);
        chk("unused_flush", 32'(FLUSH_EX), 32'd0);

        // Load-use then load in stage1
        clr();
        set_dest(0, 5'd3, 1'b1); DEST_IS_LOAD = 1'b1; set_src(0, 5'd3, 1'b1); set_src(1, 5'd4, 1'b1);
        #1;
        chk("lu_stall", 32'(STALL_ID), 32'd1);
        tick();
        chk("lu_flush", 32'(FLUSH_EX),   32'd1);
        chk("lu_fwd",   32'(FWD_SEL),    32'h0);
        chk("lu_cnt",   32'(HAZARD_CNT), 32'd1);
        set_dest(1, 5'd3, 1'b1); set_dest(0, 5'd8, 1'b1); DEST_IS_LOAD = 1'b0;
        #1;
        chk("lu2_stall", 32'(STALL_ID), 32'd0);
        tick();
        chk("lu2_fwd",   32'(FWD_SEL),    32'h2);
        chk("lu2_flush", 32'(FLUSH_EX),   32'd0);
        chk("lu2_cnt",   32'(HAZARD_CNT), 32'd1);

        // MUL/DIV stall: 3 cycles, select held, second start ignored
        do_reset();
        set_dest(0, 5'd5, 1'b1); set_src(0, 5'd5, 1'b1); MD_START = 1'b1;
        tick();
        chk("md0_busy",  32'(MD_BUSY),  32'd1);
        chk("md0_stall", 32'(STALL_ID), 32'd1);
        chk("md0_fwd",   32'(FWD_SEL),  32'h1);
        clr();
        MD_START = 1'b1;
        set_dest(0, 5'd3, 1'b1); DEST_IS_LOAD = 1'b1; set_src(1, 5'd3, 1'b1);
        tick();
        chk("md1_busy",  32'(MD_BUSY),  32'd1);
        chk("md1_flush", 32'(FLUSH_EX), 32'd0);
        chk("md1_fwd",   32'(FWD_SEL),  32'h1);
        clr();
        tick();
        chk("md2_busy",  32'(MD_BUSY),  32'd1);
        chk("md2_stall", 32'(STALL_ID), 32'd1);
        tick();
        chk("md3_busy",  32'(MD_BUSY),    32'd0);
        chk("md3_stall", 32'(STALL_ID),   32'd0);
        chk("md3_flush", 32'(FLUSH_EX),   32'd0);
        chk("md3_cnt",   32'(HAZARD_CNT), 32'd3);

        // Reset during the second cycle of MD_WAIT
        set_dest(0, 5'd5, 1'b1); set_src(0, 5'd5, 1'b1); MD_START = 1'b1;
        tick();
        clr();
        tick();
        chk("mr_busy_pre", 32'(MD_BUSY), 32'd1);
        RESET = 1'b1;
        #1;
        chk("mr_stall_rst", 32'(STALL_ID), 32'd0);
        tick();
        RESET = 1'b0;
        #1;
        chk("mr_stall", 32'(STALL_ID),   32'd0);
        chk("mr_busy",  32'(MD_BUSY),    32'd0);
        chk("mr_fwd",   32'(FWD_SEL),    32'h0);
        chk("mr_cnt",   32'(HAZARD_CNT), 32'd0);

        // Held load-use for 20 cycles: 4-bit counter saturates
        set_dest(0, 5'd12, 1'b1); DEST_IS_LOAD = 1'b1; set_src(0, 5'd12, 1'b1);
        for (int n = 0; n < 14; n++) tick();
        chk("sat_cnt14", 32'(HAZARD_CNT), 32'd14);
        for (int n = 0; n < 6; n++) tick();
        chk("sat_cnt",   32'(HAZARD_CNT), 32'd15);
        chk("sat_stall", 32'(STALL_ID),   32'd1);
        chk("sat_flush", 32'(FLUSH_EX),   32'd1);
        clr();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised operand-forwarding and hazard controller for the RV32IM pipeline.
- Compares the source registers of the instruction in ID against destination registers in NUM_FWD downstream stages, and registers an encoded forwarding select per source for use in EX on the next cycle.
- Adds what the earlier two-stage/two-source unit lacked: write-enable and x0 qualification, youngest-wins priority, load-use stall with EX bubble, a multi-cycle MUL/DIV stall FSM, and a saturating hazard counter.

Parameters:
ADDR_W, 5, register address width
NUM_SRC, 2, number of source operands per instruction
NUM_FWD, 2, forwarding stages compared (index 0 = ALU/EX dest, 1 = MEM dest, ...)
SEL_W, $clog2(NUM_FWD+1), width of each select field
MD_LAT, 4, total EX occupancy in cycles of a multi-cycle MUL/DIV op (>=2)
CNT_W, 16, hazard counter width

Ports:
CLK  in  1  clock
RESET  in  1  reset
ID_VALID  in  1  ID holds a real instruction
SRC_ADDR_ID  in  NUM_SRC*ADDR_W  source register addresses; src i = bits [i*ADDR_W +: ADDR_W]
SRC_USED_ID  in  NUM_SRC  source i is actually read
DEST_ADDR  in  NUM_FWD*ADDR_W  destination address of stage k
DEST_WE  in  NUM_FWD  stage k writes the register file
DEST_IS_LOAD  in  1  instruction in stage 0 is a load
MD_START  in  1  multi-cycle MUL/DIV entered EX this cycle
FWD_SEL  out  NUM_SRC*SEL_W  registered select per source: 0 = register file, k+1 = forward from stage k's post-edge position
STALL_ID  out  1  hold PC and IF/ID; combinational
FLUSH_EX  out  1  registered; inject bubble into EX
MD_BUSY  out  1  FSM in MD_WAIT
HAZARD_CNT  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset: RESET is synchronous and active-high; clock is CLK. On reset: FWD_SEL = 0, FLUSH_EX = 0, state = IDLE, md counter = 0, HAZARD_CNT = 0. While RESET is high, STALL_ID = 0 regardless of inputs. Reset mid-stall aborts the stall immediately.
- Match condition (comb), for source i and stage k:
  - hit[i][k] = ID_VALID & SRC_USED_ID[i] & DEST_WE[k] & (DEST_ADDR[k] == src_i) & (src_i != 0).
  - x0 is never forwarded.
- Priority: the lowest k with a hit wins (youngest producer). No hit gives sel 0.
- FWD_SEL is registered on posedge, 1-cycle latency: the value computed while the consumer is in ID is valid while it is in EX.
- Load-use (comb): lu = DEST_IS_LOAD & OR_i hit[i][0].
  - STALL_ID = lu | (state == MD_WAIT).
  - On lu, next-cycle FLUSH_EX = 1.
  - FWD_SEL for that edge is registered as 0 for every source (the bubble must not forward).
  - On the following cycle the load sits in stage 1 and the normal compare yields sel = 2. No special state is needed.
- FSM:
  - IDLE: MD_START moves to MD_WAIT and loads the counter with MD_LAT-2.
  - MD_WAIT: STALL_ID = 1 and MD_BUSY = 1. FWD_SEL holds its value; FLUSH_EX = 0 (EX is occupied, not bubbled). The counter decrements each cycle. When counter == 0, go to IDLE. Total stall = MD_LAT-1 cycles.
  - MD_START while in MD_WAIT is ignored.
- Simultaneous events:
  - lu in the same cycle as MD_START: the MD stall takes precedence and FLUSH_EX = 0. lu is re-evaluated after MD_WAIT exits.
  - lu while in MD_WAIT: masked, no flush.
- HAZARD_CNT: +1 on each cycle with STALL_ID = 1; saturates at all-ones and never wraps.
- All outputs are driven without # delays. The unit is pure RTL and synthesizable.

Test Plan:
1. ALU-to-ALU dependency: stage0 dest=5 WE=1, ID src0=5 used, src1=6 -> after edge FWD_SEL[src0]=1, FWD_SEL[src1]=0, STALL_ID=0.
2. Priority and x0:
   - stage0 and stage1 both dest=7, src1=7 -> sel=1.
   - stage0 dest=0 WE=1, src0=0 -> sel=0.
   - DEST_WE[0]=0 with dest=7 and only stage1 matching -> sel=2.
3. Load-use: DEST_IS_LOAD=1, stage0 dest=3, src0=3 -> STALL_ID=1 same cycle; next cycle FLUSH_EX=1 and FWD_SEL=0. Then with stage1 dest=3 -> sel=2, STALL_ID=0. HAZARD_CNT=1.
4. MD stall with MD_LAT=4: pulse MD_START -> STALL_ID=1 and MD_BUSY=1 for exactly 3 cycles. FLUSH_EX stays 0; a second MD_START mid-wait has no effect. HAZARD_CNT=3.
5. Reset mid-MD_WAIT: assert RESET at cycle 2 of the wait -> next edge STALL_ID=0, MD_BUSY=0, FWD_SEL=0, HAZARD_CNT=0.
6. Saturation with CNT_W=4: hold a stall for 20 cycles -> HAZARD_CNT stops at 15. Also cover SRC_USED_ID=0 on a matching address -> sel=0 and no stall.
